// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte with odd parity
// on device clock falls, capture the device ACK, and time out on a stalled bus.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       ps2_c_in,
  input  logic       ps2_d_in,
  output logic       ps2_c_oe,
  output logic       ps2_d_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StReq      = 3'd2;
  localparam logic [2:0] StShift    = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;

  logic [FILTER_LEN-1:0] c_sr_q, c_sr_d, d_sr_q, d_sr_d;
  logic                  c_filt_q, c_filt_d, d_filt_q, d_filt_d;
  logic                  c_prev_q;
  logic                  fall;

  logic [2:0]      state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            nack_q, nack_d;
  logic            c_oe_q, c_oe_d, d_oe_q, d_oe_d;
  logic            ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic            active, timeout;

  // Glitch filter: the filtered level only moves when the whole window agrees.
  always_comb begin
    c_sr_d   = {c_sr_q[FILTER_LEN-2:0], ps2_c_in};
    d_sr_d   = {d_sr_q[FILTER_LEN-2:0], ps2_d_in};
    c_filt_d = c_filt_q;
    d_filt_d = d_filt_q;
    if (&c_sr_q)       c_filt_d = 1'b1;
    else if (~|c_sr_q) c_filt_d = 1'b0;
    if (&d_sr_q)       d_filt_d = 1'b1;
    else if (~|d_sr_q) d_filt_d = 1'b0;
  end

  assign fall = c_prev_q & ~c_filt_q;

  assign active  = (state_q == StShift) || (state_q == StAck) || (state_q == StWaitIdle);
  assign timeout = active && (to_cnt_q == ToLast);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_idx_d = bit_idx_q;
    nack_d    = nack_q;
    c_oe_d    = c_oe_q;
    d_oe_d    = d_oe_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (active) begin
      to_cnt_d = fall ? '0 : to_cnt_q + ToW'(1);
    end

    if (timeout) begin
      // Stalled device: abandon the frame regardless of any coincident fall.
      state_d = StIdle;
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          c_oe_d = 1'b0;
          d_oe_d = 1'b0;
          if (tx_valid && ready_q) begin
            data_d    = tx_data;
            parity_d  = ~^tx_data;
            ready_d   = 1'b0;
            err_d     = 1'b0;
            inh_cnt_d = '0;
            c_oe_d    = 1'b1;
            state_d   = StInhibit;
          end else begin
            ready_d = 1'b1;
          end
        end
        StInhibit: begin
          c_oe_d = 1'b1;
          if (inh_cnt_q == InhLast) begin
            d_oe_d  = 1'b1;
            state_d = StReq;
          end else begin
            inh_cnt_d = inh_cnt_q + InhW'(1);
          end
        end
        StReq: begin
          // Release the clock with the start bit already on the data line.
          c_oe_d    = 1'b0;
          d_oe_d    = 1'b1;
          bit_idx_d = '0;
          to_cnt_d  = '0;
          state_d   = StShift;
        end
        StShift: begin
          if (fall) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              d_oe_d = ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              d_oe_d = ~parity_q;
            end else begin
              d_oe_d  = 1'b0;
              state_d = StAck;
            end
          end
        end
        StAck: begin
          d_oe_d = 1'b0;
          if (fall) begin
            nack_d  = d_filt_q;
            state_d = StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (c_filt_q && d_filt_q) begin
            done_d  = 1'b1;
            err_d   = nack_q;
            state_d = StIdle;
          end
        end
        default: begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      c_sr_q    <= '1;
      d_sr_q    <= '1;
      c_filt_q  <= 1'b1;
      d_filt_q  <= 1'b1;
      c_prev_q  <= 1'b1;
      state_q   <= StIdle;
      data_q    <= '0;
      parity_q  <= 1'b0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_idx_q <= '0;
      nack_q    <= 1'b0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      c_sr_q    <= c_sr_d;
      d_sr_q    <= d_sr_d;
      c_filt_q  <= c_filt_d;
      d_filt_q  <= d_filt_d;
      c_prev_q  <= c_filt_q;
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_idx_q <= bit_idx_d;
      nack_q    <= nack_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_c_oe = c_oe_q;
  assign ps2_d_oe = d_oe_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model on both lines.
module tb_ps2_host_tx;

  localparam int unsigned InhCycles = 100;
  localparam int unsigned ToCycles  = 5000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_c_in, ps2_d_in, ps2_c_oe, ps2_d_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_err;
  logic       dev_c_low, dev_d_low, c_glitch;
  logic       c_line, d_line;
  int         vecs = 0;
  int         errs = 0;
  int         done_cnt = 0;

  assign c_line   = ~(ps2_c_oe | dev_c_low);
  assign d_line   = ~(ps2_d_oe | dev_d_low);
  assign ps2_c_in = c_line & ~c_glitch;
  assign ps2_d_in = d_line;

  ps2_host_tx #(
    .INHIBIT_CYCLES (InhCycles),
    .TIMEOUT_CYCLES (ToCycles),
    .FILTER_LEN     (4)
  ) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .ps2_c_in   (ps2_c_in),
    .ps2_d_in   (ps2_d_in),
    .ps2_c_oe   (ps2_c_oe),
    .ps2_d_oe   (ps2_d_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  // Keyboard side: 40-cycle clock, data sampled on each rising edge, ACK slot on pulse 11.
  task automatic dev_frame(input logic ack, input int npulse, input logic glitch,
                           output logic [9:0] bits, output logic found, output logic early);
    int start_dc;
    found = 1'b0;
    early = 1'b0;
    bits  = '0;
    for (int i = 0; i < 2000; i++) begin
      if (c_line && !d_line) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) return;
    wait_cycles(10);
    start_dc = done_cnt;
    for (int p = 1; p <= npulse; p++) begin
      if (p == 11) begin
        dev_d_low = ack;
        wait_cycles(5);
      end
      dev_c_low = 1'b1;
      wait_cycles(20);
      dev_c_low = 1'b0;
      if (p <= 10) bits[p-1] = d_line;
      if (glitch && p <= 10) begin
        wait_cycles(6);
        c_glitch = 1'b1;
        wait_cycles(2);
        c_glitch = 1'b0;
        if (p == 3) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          step();
          tx_valid = 1'b0;
          wait_cycles(11);
        end else begin
          wait_cycles(12);
        end
      end else begin
        wait_cycles(20);
      end
      if (p == 10) early = (done_cnt != start_dc);
    end
    dev_d_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic ack, input logic glitch,
                           output logic [9:0] bits, output logic found, output logic early,
                           output logic done_seen);
    int dc0;
    dc0 = done_cnt;
    accept(d);
    dev_frame(ack, 11, glitch, bits, found, early);
    done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != dc0) begin
        done_seen = 1'b1;
        break;
      end
      step();
    end
    wait_cycles(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    vecs++; if (ps2_c_oe !== 1'b0) begin errs++; $display("FAIL reset_c_oe: got %b want 0", ps2_c_oe); end
    vecs++; if (ps2_d_oe !== 1'b0) begin errs++; $display("FAIL reset_d_oe: got %b want 0", ps2_d_oe); end
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    vecs++; if (tx_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", tx_done); end
    vecs++; if (tx_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", tx_err); end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_basic();
    logic [9:0] bits;
    logic       found, early, seen;
    int         n, dc0;
    dc0 = done_cnt;
    accept(8'hED);
    vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL basic_busy: ready %b want 0", tx_ready); end
    n = 0;
    while (ps2_c_oe === 1'b1 && ps2_d_oe === 1'b0 && n < 1000) begin
      n++;
      step();
    end
    vecs++; if (n != InhCycles) begin errs++; $display("FAIL basic_inhibit: %0d cycles want %0d", n, InhCycles); end
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b11) begin
      errs++; $display("FAIL basic_req: c/d oe %b%b want 11", ps2_c_oe, ps2_d_oe);
    end
    step();
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b01) begin
      errs++; $display("FAIL basic_release: c/d oe %b%b want 01", ps2_c_oe, ps2_d_oe);
    end
    dev_frame(1'b1, 11, 1'b0, bits, found, early);
    vecs++; if (found !== 1'b1) begin errs++; $display("FAIL basic_start: found %b want 1", found); end
    vecs++; if (bits !== 10'b11_1110_1101) begin
      errs++; $display("FAIL basic_bits: got %b want 1111101101", bits);
    end
    vecs++; if (early !== 1'b0) begin errs++; $display("FAIL basic_early_done: got %b want 0", early); end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL basic_done: seen %b want 1", seen); end
    vecs++; if (tx_err !== 1'b0) begin errs++; $display("FAIL basic_err: got %b want 0", tx_err); end
    vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL basic_ready_at_done: got %b want 0", tx_ready); end
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b00) begin
      errs++; $display("FAIL basic_oe_idle: c/d oe %b%b want 00", ps2_c_oe, ps2_d_oe);
    end
    step();
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL basic_ready_after: got %b want 1", tx_ready); end
    vecs++; if (done_cnt != dc0 + 1) begin
      errs++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - dc0, 1);
    end
    wait_cycles(5);
  endtask

  task automatic test_parity();
    logic [7:0] din [3];
    logic [9:0] want [3];
    logic [9:0] bits;
    logic       found, early, seen;
    din[0] = 8'h00; want[0] = 10'b11_0000_0000;
    din[1] = 8'hFF; want[1] = 10'b11_1111_1111;
    din[2] = 8'h01; want[2] = 10'b10_0000_0001;
    for (int v = 0; v < 3; v++) begin
      run_frame(din[v], 1'b1, 1'b0, bits, found, early, seen);
      vecs++; if (bits !== want[v] || found !== 1'b1) begin
        errs++; $display("FAIL parity_bits[%0h]: got %b want %b", din[v], bits, want[v]);
      end
      vecs++; if (early !== 1'b0 || seen !== 1'b1) begin
        errs++; $display("FAIL parity_frame_len[%0h]: early %b done %b want 0 1", din[v], early, seen);
      end
      vecs++; if (tx_err !== 1'b0) begin
        errs++; $display("FAIL parity_err[%0h]: got %b want 0", din[v], tx_err);
      end
    end
  endtask

  task automatic test_nack();
    logic [9:0] bits;
    logic       found, early, seen;
    run_frame(8'h5A, 1'b0, 1'b0, bits, found, early, seen);
    vecs++; if (bits !== 10'b11_0101_1010) begin errs++; $display("FAIL nack_bits: got %b want 1101011010", bits); end
    vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL nack_done: seen %b want 1", seen); end
    vecs++; if (tx_err !== 1'b1) begin errs++; $display("FAIL nack_err: got %b want 1", tx_err); end
    vecs++; if ({ps2_c_oe, ps2_d_oe, tx_ready} !== 3'b001) begin
      errs++; $display("FAIL nack_idle: c_oe d_oe ready %b%b%b want 001", ps2_c_oe, ps2_d_oe, tx_ready);
    end
  endtask

  task automatic test_timeout();
    logic rel;
    int   k;
    accept(8'hAA);
    rel = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (ps2_c_oe === 1'b0 && ps2_d_oe === 1'b1) begin
        rel = 1'b1;
        break;
      end
      step();
    end
    vecs++; if (rel !== 1'b1) begin errs++; $display("FAIL timeout_release: seen %b want 1", rel); end
    k = 0;
    while (tx_done !== 1'b1 && k < ToCycles + 1000) begin
      step();
      k++;
    end
    vecs++; if (k != ToCycles) begin errs++; $display("FAIL timeout_cycles: got %0d want %0d", k, ToCycles); end
    vecs++; if (tx_err !== 1'b1) begin errs++; $display("FAIL timeout_err: got %b want 1", tx_err); end
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b00) begin
      errs++; $display("FAIL timeout_oe: c/d oe %b%b want 00", ps2_c_oe, ps2_d_oe);
    end
    step();
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
    wait_cycles(5);
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    logic       found, early, seen;
    accept(8'h2C);
    dev_frame(1'b1, 5, 1'b0, bits, found, early);
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b01) begin
      errs++; $display("FAIL rstmid_bit4: c/d oe %b%b want 01", ps2_c_oe, ps2_d_oe);
    end
    #1 rst_n = 1'b0;
    #1;
    vecs++; if ({ps2_c_oe, ps2_d_oe} !== 2'b00) begin
      errs++; $display("FAIL rstmid_oe: c/d oe %b%b want 00", ps2_c_oe, ps2_d_oe);
    end
    vecs++; if ({tx_ready, tx_err, tx_done} !== 3'b100) begin
      errs++; $display("FAIL rstmid_status: ready err done %b%b%b want 100", tx_ready, tx_err, tx_done);
    end
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
    run_frame(8'hFF, 1'b1, 1'b0, bits, found, early, seen);
    vecs++; if (bits !== 10'b11_1111_1111 || seen !== 1'b1) begin
      errs++; $display("FAIL rstmid_resend: bits %b done %b want 1111111111 1", bits, seen);
    end
    vecs++; if (tx_err !== 1'b0) begin errs++; $display("FAIL rstmid_resend_err: got %b want 0", tx_err); end
  endtask

  task automatic test_glitch_busy();
    logic [9:0] bits;
    logic       found, early, seen;
    int         dc0;
    dc0 = done_cnt;
    run_frame(8'hA5, 1'b1, 1'b1, bits, found, early, seen);
    vecs++; if (bits !== 10'b11_1010_0101) begin errs++; $display("FAIL glitch_bits: got %b want 1110100101", bits); end
    vecs++; if (early !== 1'b0 || seen !== 1'b1) begin
      errs++; $display("FAIL glitch_frame_len: early %b done %b want 0 1", early, seen);
    end
    vecs++; if (tx_err !== 1'b0) begin errs++; $display("FAIL glitch_err: got %b want 0", tx_err); end
    wait_cycles(150);
    vecs++; if (done_cnt != dc0 + 1) begin
      errs++; $display("FAIL glitch_done_count: got %0d want 1", done_cnt - dc0);
    end
    vecs++; if ({ps2_c_oe, tx_ready} !== 2'b01) begin
      errs++; $display("FAIL glitch_no_new_tx: c_oe ready %b%b want 01", ps2_c_oe, tx_ready);
    end
  endtask

  initial begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    c_glitch  = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_glitch_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
